// File: rtl/stack_program_sequencer.sv
// Program sequencer that feeds (opcode, operand) words from a small flop memory to the stack machine.
// Optional macro SINGLE_STEP_EN adds a 'step' input that gates instruction issue in RUN.
module stack_program_sequencer #(
  parameter int N  = 8,
  parameter int D  = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [2:0]    load_op,
  input  logic [N-1:0]  load_data,
  input  logic          start,
  input  logic [N-1:0]  result_in,
`ifdef SINGLE_STEP_EN
  input  logic          step,
`endif
  output logic [N-1:0]  x,
  output logic [2:0]    opcode,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  result,
  output logic          result_valid
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [2:0]    OP_HALT = 3'd7;
  localparam logic [AW-1:0] LAST    = AW'(D - 1);

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_mem_op   [D];
  logic [N-1:0]  r_mem_data [D];
  logic [AW-1:0] r_pc, w_pc_nxt;
  logic [2:0]    r_op, w_op_nxt;
  logic [N-1:0]  r_x, w_x_nxt;
  logic          r_wrap, w_wrap_nxt;
  logic          r_done, w_done_nxt;
  logic [N-1:0]  r_result, w_result_nxt;
  logic          r_rv, w_rv_nxt;
  logic          w_idle;
  logic          w_step;
  logic [2:0]    w_word_op;
  logic [N-1:0]  w_word_data;

`ifdef SINGLE_STEP_EN
  assign w_step = step;
`else
  assign w_step = 1'b1;
`endif

  assign w_idle      = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_word_op   = r_mem_op[r_pc];
  assign w_word_data = r_mem_data[r_pc];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < D; i++) begin
        r_mem_op[i]   <= OP_HALT;
        r_mem_data[i] <= '0;
      end
    end else if (load_en && w_idle) begin
      r_mem_op[load_addr]   <= load_op;
      r_mem_data[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_op     <= '0;
      r_x      <= '0;
      r_wrap   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_rv     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_op     <= w_op_nxt;
      r_x      <= w_x_nxt;
      r_wrap   <= w_wrap_nxt;
      r_done   <= w_done_nxt;
      r_result <= w_result_nxt;
      r_rv     <= w_rv_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_op_nxt     = 3'd0;
    w_x_nxt      = '0;
    w_wrap_nxt   = r_wrap;
    w_done_nxt   = 1'b0;
    w_result_nxt = r_result;
    w_rv_nxt     = r_rv;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = '0;
          w_rv_nxt    = 1'b0;
          w_wrap_nxt  = 1'b0;
        end
      end
      S_RUN: begin
        if (w_step) begin
          // After the last word the wrap flag acts as a HALT slot, so the
          // stack machine consumes that word before the result is captured.
          if (r_wrap || (w_word_op == OP_HALT)) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_op_nxt = w_word_op;
            w_x_nxt  = w_word_data;
            w_pc_nxt = r_pc + AW'(1);
            if (r_pc == LAST) w_wrap_nxt = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        w_result_nxt = result_in;
        w_rv_nxt     = 1'b1;
        w_done_nxt   = 1'b1;
        w_state_nxt  = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign x            = r_x;
  assign opcode       = r_op;
  assign pc           = r_pc;
  assign busy         = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done         = r_done;
  assign result       = r_result;
  assign result_valid = r_rv;

endmodule

// File: tb/tb_stack_program_sequencer.sv
// Directed bench for stack_program_sequencer with a small behavioural stack machine on result_in.
module tb_stack_program_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_en = 1'b0;
  logic [3:0] load_addr = '0;
  logic [2:0] load_op = '0;
  logic [7:0] load_data = '0;
  logic       start = 1'b0;
  logic [7:0] result_in;
  logic       step = 1'b1;
  logic [7:0] x;
  logic [2:0] opcode;
  logic [3:0] pc;
  logic       busy, done;
  logic [7:0] result;
  logic       result_valid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stack_program_sequencer #(.N(8), .D(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_op(load_op), .load_data(load_data), .start(start),
    .result_in(result_in),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .x(x), .opcode(opcode), .pc(pc), .busy(busy), .done(done),
    .result(result), .result_valid(result_valid)
  );

  // Stack machine model: consumes the registered opcode/x on the next edge.
  logic [7:0] stk [0:63];
  logic [5:0] sp;
  always @(posedge clk or negedge rst) begin
    if (!rst) sp <= 6'd0;
    else begin
      case (opcode)
        3'd1: if (sp >= 6'd2) begin stk[sp-6'd2] <= stk[sp-6'd2] + stk[sp-6'd1]; sp <= sp - 6'd1; end
        3'd2: if (sp >= 6'd2) begin stk[sp-6'd2] <= stk[sp-6'd2] - stk[sp-6'd1]; sp <= sp - 6'd1; end
        3'd3: if (sp >= 6'd2) begin stk[sp-6'd2] <= stk[sp-6'd2] * stk[sp-6'd1]; sp <= sp - 6'd1; end
        3'd4: if (sp < 6'd63) begin stk[sp] <= x; sp <= sp + 6'd1; end
        default: ;
      endcase
    end
  end
  assign result_in = (sp == 6'd0) ? 8'd0 : stk[sp-6'd1];

  typedef struct {
    logic       start;
    logic [2:0] op;
    logic [7:0] x;
    logic [3:0] pc;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       rv;
  } vec_t;

  vec_t vt [11];

  task automatic chk_all(input string nm, input vec_t e);
    n_vec++;
    if (opcode !== e.op || x !== e.x || pc !== e.pc || busy !== e.busy ||
        done !== e.done || result !== e.result || result_valid !== e.rv) begin
      n_err++;
      $display("FAIL %s: got op=%0d x=%0d pc=%0d busy=%b done=%b result=%0d rv=%b, want op=%0d x=%0d pc=%0d busy=%b done=%b result=%0d rv=%b",
               nm, opcode, x, pc, busy, done, result, result_valid,
               e.op, e.x, e.pc, e.busy, e.done, e.result, e.rv);
    end
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic load(input int a, input int o, input int d);
    load_en   = 1'b1;
    load_addr = 4'(a);
    load_op   = 3'(o);
    load_data = 8'(d);
    tick();
    load_en = 1'b0;
  endtask

  task automatic load_prog1();
    load(0, 4, 2); load(1, 4, 4); load(2, 4, 5); load(3, 3, 0);
    load(4, 4, 6); load(5, 1, 0); load(6, 1, 0); load(7, 7, 0);
  endtask

  task automatic load_prog2();
    load(0, 4, 9); load(1, 4, 3); load(2, 2, 0); load(3, 7, 0);
  endtask

  // Pulses start, then counts edges until done; cyc stays -1 on timeout.
  task automatic run_prog(input int maxc, output int cyc, output int pushes);
    cyc = -1;
    pushes = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= maxc; k++) begin
      tick();
      if (opcode == 3'd4) pushes++;
      if (done) begin cyc = k; break; end
    end
  endtask

  initial begin
    int cyc, pushes;
    vec_t zero;

    zero = '{1'b0, 3'd0, 8'd0, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0};
    //           start op    x      pc     busy  done  result rv
    vt[0]  = '{1'b1, 3'd0, 8'd0, 4'd0, 1'b1, 1'b0, 8'd0,  1'b0};
    vt[1]  = '{1'b0, 3'd4, 8'd2, 4'd1, 1'b1, 1'b0, 8'd0,  1'b0};
    vt[2]  = '{1'b0, 3'd4, 8'd4, 4'd2, 1'b1, 1'b0, 8'd0,  1'b0};
    vt[3]  = '{1'b0, 3'd4, 8'd5, 4'd3, 1'b1, 1'b0, 8'd0,  1'b0};
    vt[4]  = '{1'b0, 3'd3, 8'd0, 4'd4, 1'b1, 1'b0, 8'd0,  1'b0};
    vt[5]  = '{1'b0, 3'd4, 8'd6, 4'd5, 1'b1, 1'b0, 8'd0,  1'b0};
    vt[6]  = '{1'b0, 3'd1, 8'd0, 4'd6, 1'b1, 1'b0, 8'd0,  1'b0};
    vt[7]  = '{1'b0, 3'd1, 8'd0, 4'd7, 1'b1, 1'b0, 8'd0,  1'b0};
    vt[8]  = '{1'b0, 3'd0, 8'd0, 4'd7, 1'b1, 1'b0, 8'd0,  1'b0};
    vt[9]  = '{1'b0, 3'd0, 8'd0, 4'd7, 1'b0, 1'b1, 8'd28, 1'b1};
    vt[10] = '{1'b0, 3'd0, 8'd0, 4'd7, 1'b0, 1'b0, 8'd28, 1'b1};

    tick(); tick();
    chk_all("reset_state", zero);
    rst = 1'b1;

    // Program 2+4*5+6 stepped cycle by cycle from the table
    load_prog1();
    for (int i = 0; i < 11; i++) begin
      start = vt[i].start;
      tick();
      start = 1'b0;
      chk_all($sformatf("prog1_edge%0d", i), vt[i]);
    end

    // 9-3 with HALT after three words
    do_reset();
    load_prog2();
    run_prog(40, cyc, pushes);
    chk("sub_done_edge", cyc, 5);
    chk("sub_result", int'(result), 6);
    chk("sub_valid", int'(result_valid), 1);
    chk("sub_busy_after", int'(busy), 0);
    tick();
    chk("sub_done_pulse_end", int'(done), 0);

    // All sixteen words are pushes; pc wraps and the run ends on its own
    do_reset();
    for (int k = 1; k <= 16; k++) load(k - 1, 4, k);
    run_prog(60, cyc, pushes);
    chk("wrap_finished", int'(cyc > 0), 1);
    chk("wrap_pushes", pushes, 16);
    chk("wrap_result", int'(result), 16);
    chk("wrap_pc", int'(pc), 0);

    // start and load_en during RUN are both ignored
    do_reset();
    load_prog2();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; load_en = 1'b1; load_addr = 4'd0; load_op = 3'd7; load_data = 8'd0;
    tick();
    start = 1'b0; load_en = 1'b0;
    cyc = -1;
    for (int k = 3; k <= 40; k++) begin
      tick();
      if (done) begin cyc = k; break; end
    end
    chk("ignore_done_edge", cyc, 5);
    chk("ignore_result", int'(result), 6);
    // Reload after DONE turns the program into an empty one
    load(0, 7, 0);
    run_prog(40, cyc, pushes);
    chk("reload_done_edge", cyc, 2);
    chk("reload_pushes", pushes, 0);
    chk("reload_result", int'(result), 6);

    // Asynchronous reset in the middle of a run
    do_reset();
    load_prog1();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("midrun_third_push", int'(x), 5);
    #1;
    rst = 1'b0;
    #1;
    chk_all("midrun_reset_outputs", zero);
    #1;
    rst = 1'b1;
    run_prog(40, cyc, pushes);
    chk("after_reset_done_edge", cyc, 2);
    chk("after_reset_pushes", pushes, 0);
    chk("after_reset_result", int'(result), 0);
    chk("after_reset_valid", int'(result_valid), 1);

`ifdef SINGLE_STEP_EN
    begin
      int bad;
      int ops;
      logic prev_step;
      do_reset();
      load_prog1();
      bad = 0;
      ops = 0;
      cyc = -1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 80; k++) begin
        step = (k % 3 == 0);
        prev_step = step;
        tick();
        if (!prev_step && busy && opcode != 3'd0) bad++;
        if (opcode != 3'd0) ops++;
        if (done) begin cyc = k; break; end
      end
      step = 1'b1;
      chk("step_finished", int'(cyc > 0), 1);
      chk("step_nop_between", bad, 0);
      chk("step_issued", ops, 7);
      chk("step_result", int'(result), 28);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
